// File: rtl/x_feed_ctrl.sv
// Load/stream sequencer for LANES shift-register lanes: lane-major load, then skewed or lockstep emit.
// Optional macro X_FEED_SKEW_EN selects the one-cycle-per-lane skewed STREAM schedule.
module x_feed_ctrl #(
  parameter int LANES = 4,
  parameter int DEPTH = 32,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [LANES-1:0] lane_en,
  output logic             lane_write,
  output logic [4:0]       lane_idx,
  output logic [DW-1:0]    lane_din,
  output logic [LANES-1:0] out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW  = ($clog2(DEPTH + LANES) + 1 > 8) ? $clog2(DEPTH + LANES) + 1 : 8;
  localparam int LNW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    l_len;
  logic [CW-1:0]    cnt;
  logic [4:0]       row;
  logic [LNW-1:0]   lane;
  logic [LANES-1:0] stream_en;
  logic             accept, row_last, lane_last, cnt_last;

  // Zero or oversize lengths mean a full-depth job.
  function automatic logic [CW-1:0] clamp_len(input logic [5:0] v);
    if (v == 6'd0 || CW'(v) > CW'(DEPTH)) return CW'(DEPTH);
    return CW'(v);
  endfunction

  assign accept    = (state == LOAD) && in_valid;
  assign row_last  = CW'(row) == l_len - CW'(1);
  assign lane_last = lane == LNW'(LANES - 1);

`ifdef X_FEED_SKEW_EN
  assign cnt_last = cnt == l_len + CW'(LANES) - CW'(2);
  always_comb begin
    for (int k = 0; k < LANES; k++)
      stream_en[k] = (cnt >= CW'(k)) && (cnt < CW'(k) + l_len);
  end
`else
  assign cnt_last  = cnt == l_len - CW'(1);
  assign stream_en = (cnt < l_len) ? '1 : '0;
`endif

  // State register, job counters and the lane DOUT-latency strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      l_len     <= '0;
      cnt       <= '0;
      row       <= '0;
      lane      <= '0;
      out_valid <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state == STREAM) ? stream_en : '0;
      case (state)
        IDLE: if (start) begin
          l_len <= clamp_len(len);
          cnt   <= '0;
          row   <= '0;
          lane  <= '0;
        end
        LOAD: if (accept) begin
          if (row_last) begin
            row  <= '0;
            lane <= lane_last ? '0 : lane + LNW'(1);
          end else begin
            row <= row + 5'd1;
          end
        end
        STREAM: cnt <= cnt_last ? '0 : cnt + CW'(1);
        default: ;
      endcase
    end
  end

  // Next state and combinational strobes
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    lane_en    = '0;
    lane_write = 1'b0;
    lane_idx   = '0;
    lane_din   = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (accept) begin
          lane_en    = LANES'(1) << lane;
          lane_write = 1'b1;
          lane_idx   = row;
          lane_din   = in_data;
          if (row_last && lane_last) state_nxt = STREAM;
        end
      end
      STREAM: begin
        lane_en = stream_en;
        if (cnt_last) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_x_feed_ctrl.sv
// Randomized bench for x_feed_ctrl against a lane-major / window-schedule reference model.
// Honours X_FEED_SKEW_EN the same way as the design.
module tb_x_feed_ctrl;
  localparam int LANES = 4;
  localparam int DEPTH = 32;
  localparam int DW    = 16;

  logic             clk = 1'b0;
  logic             rst, start, in_valid;
  logic [5:0]       len;
  logic [DW-1:0]    in_data;
  logic             in_ready, lane_write, busy, done;
  logic [LANES-1:0] lane_en, out_valid;
  logic [4:0]       lane_idx;
  logic [DW-1:0]    lane_din;

  int compared = 0;
  int mismatched = 0;

  x_feed_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lane_en(lane_en), .lane_write(lane_write), .lane_idx(lane_idx),
    .lane_din(lane_din), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Lane k is live on stream cycle c when c-L < k <= c (skew) or whenever c < L (lockstep).
  function automatic logic [LANES-1:0] exp_stream(input int c, input int l);
`ifdef X_FEED_SKEW_EN
    logic [63:0] hi, lo;
    hi = (c + 1 >= 64) ? '1 : (64'd1 << (c + 1)) - 64'd1;
    lo = (c - l + 1 <= 0) ? 64'd0 : (64'd1 << (c - l + 1)) - 64'd1;
    return LANES'(hi & ~lo);
`else
    return (c < l) ? '1 : '0;
`endif
  endfunction

  task automatic idle_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_lane_en"}, 64'(lane_en), 64'd0);
    check({tag, "_write"}, 64'(lane_write), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // vmode: 0 = in_valid always high, 1 = toggling starting high, 2 = random.
  task automatic run_job(input int len_in, input int vmode, input bit seqdata, input int abort_c);
    int l, s, n, cyc, ov0;
    logic             v;
    logic [DW-1:0]    d;
    logic [LANES-1:0] e, prev;
    l = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
`ifdef X_FEED_SKEW_EN
    s = l + LANES - 1;
`else
    s = l;
`endif
    start = 1'b1; len = 6'(len_in); in_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < l * LANES && cyc < 4 * l * LANES + 16) begin
      case (vmode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = seqdata ? DW'(n + 1) : DW'($urandom);
      in_valid = v; in_data = d;
      start = 1'($urandom_range(0, 1)); len = 6'($urandom);
      @(negedge clk);
      check("load_ready", 64'(in_ready), 64'd1);
      check("load_busy", 64'(busy), 64'd1);
      check("load_done", 64'(done), 64'd0);
      check("load_lane_en", 64'(lane_en), v ? (64'd1 << (n / l)) : 64'd0);
      check("load_write", 64'(lane_write), 64'(v));
      check("load_idx", 64'(lane_idx), v ? 64'(n % l) : 64'd0);
      check("load_din", 64'(lane_din), v ? 64'(d) : 64'd0);
      check("load_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      if (v) n++;
      cyc++;
    end
    check("load_words", 64'(n), 64'(l * LANES));
    in_valid = 1'b0;
    prev = '0; ov0 = 0;
    for (int c = 0; c < s; c++) begin
      e = exp_stream(c, l);
      start = 1'($urandom_range(0, 1)); len = 6'($urandom);
      @(negedge clk);
      check("stream_lane_en", 64'(lane_en), 64'(e));
      check("stream_write", 64'(lane_write), 64'd0);
      check("stream_idx", 64'(lane_idx), 64'd0);
      check("stream_din", 64'(lane_din), 64'd0);
      check("stream_ready", 64'(in_ready), 64'd0);
      check("stream_busy", 64'(busy), 64'd1);
      check("stream_done", 64'(done), 64'd0);
      check("stream_out_valid", 64'(out_valid), 64'(prev));
      if (out_valid[0]) ov0++;
      if (c == abort_c) begin
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        idle_outputs_zero("abort");
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      prev = e;
    end
    start = 1'b0;
    @(negedge clk);
    check("fin_done", 64'(done), 64'd1);
    check("fin_busy", 64'(busy), 64'd1);
    check("fin_out_valid", 64'(out_valid), 64'(prev));
    check("fin_lane_en", 64'(lane_en), 64'd0);
    check("fin_ready", 64'(in_ready), 64'd0);
    if (out_valid[0]) ov0++;
    check("lane0_pulses", 64'(ov0), 64'(l));
    @(posedge clk); #1;
    @(negedge clk);
    idle_outputs_zero("post_fin");
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    idle_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(4, 0, 1'b1, -1);
    run_job(2, 0, 1'b0, -1);
    run_job(0, 0, 1'b0, -1);
    run_job(3, 1, 1'b0, -1);
    run_job(5, 2, 1'b0, 2);
    run_job(5, 2, 1'b0, -1);

    rst = 1'b1; start = 1'b1; len = 6'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    idle_outputs_zero("rst_vs_start");
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run_job(int'($urandom_range(0, 63)), 2, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/x_feed_ctrl.md
X_FEED_CTRL -- requirements
Module: x_feed_ctrl

Interface
REQ-001 Parameter LANES, default 4, number of shift-register lanes sequenced.
REQ-002 Parameter DEPTH, default 32, entries per lane; LANE_IDX width is 5.
REQ-003 Parameter DW, default 16, data width.
REQ-004 CLK  in  1  single clock; all state updates on posedge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 START  in  1  begin a load/stream job; sampled only in IDLE.
REQ-007 LEN  in  6  rows per lane for the job; latched on accepted START.
REQ-008 IN_VALID  in  1  load data valid.
REQ-009 IN_READY  out  1  controller accepts IN_DATA this cycle.
REQ-010 IN_DATA  in  DW  load word.
REQ-011 LANE_EN  out  LANES  per-lane enable strobe.
REQ-012 LANE_WRITE  out  1  1 = write at LANE_IDX, 0 = shift/emit.
REQ-013 LANE_IDX  out  5  write index.
REQ-014 LANE_DIN  out  DW  write data.
REQ-015 OUT_VALID  out  LANES  lane k DOUT holds a new row this cycle.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 DONE  out  1  one-cycle job-complete pulse.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, STREAM, FIN.
REQ-019 IDLE -> LOAD when START=1; LEN latched as L, where LEN=0 or LEN>DEPTH is clamped to DEPTH.
REQ-020 LOAD: IN_READY=1; a word is accepted when IN_VALID && IN_READY.
REQ-021 Words arrive lane-major: lane 0 rows 0..L-1, then lane 1, ..., lane LANES-1.
REQ-022 On acceptance, in the same cycle (combinational from IN_*), LANE_EN is one-hot at the current lane, LANE_WRITE=1, LANE_IDX=row, LANE_DIN=IN_DATA; otherwise LANE_EN=0.
REQ-023 Row counter increments per accepted word and wraps to 0 at L-1 with lane increment; IN_VALID=0 stalls with no state change.
REQ-024 LOAD -> STREAM on the edge after the L*LANES-th accepted word; IN_READY=0 outside LOAD.
REQ-025 STREAM: counter c runs 0..L+LANES-2; LANE_WRITE=0; LANE_EN[k]=1 iff k <= c < k+L (one-cycle skew per lane).
REQ-026 OUT_VALID[k] SHALL be LANE_EN[k] of STREAM delayed one cycle (lane DOUT register latency).
REQ-027 STREAM -> FIN after c=L+LANES-2; FIN asserts DONE for exactly one cycle, with the final OUT_VALID, then -> IDLE.
REQ-028 START outside IDLE SHALL be ignored; LEN changes outside IDLE SHALL have no effect.
REQ-029 LANE_IDX and LANE_DIN SHALL be 0 whenever LANE_WRITE=0.

Reset
REQ-030 RST=1 at a posedge SHALL force IDLE, zero all counters, and drive IN_READY, LANE_EN, LANE_WRITE, OUT_VALID, BUSY, DONE to 0 in the next cycle.
REQ-031 RST mid-LOAD or mid-STREAM aborts the job with no DONE; lane contents are not cleared.
REQ-032 RST has priority over START in the same cycle.

Configuration
REQ-033 Macro X_FEED_SKEW_EN defined: STREAM skew per REQ-025; duration L+LANES-1 cycles.
REQ-034 X_FEED_SKEW_EN undefined: LANE_EN[k]=1 for all k when c < L; STREAM lasts L cycles; OUT_VALID is all lanes in lockstep.

Verification
REQ-035 LEN=4, LANES=4, IN_VALID held high, data 1..16 -> 16 write cycles, lane 0 IDX 0..3 = 1..4, lane 3 IDX 3 = 16; STREAM 7 cycles; DONE 1 cycle after the 7th STREAM cycle.
REQ-036 SKEW_EN, LEN=2 -> LANE_EN per STREAM cycle: 0001, 0011, 0110, 1100, 1000; OUT_VALID is the same sequence one cycle later.
REQ-037 LEN=0 -> clamped to 32; exactly 128 words accepted; lane 0 emits 32 OUT_VALID pulses.
REQ-038 IN_VALID toggled 1/0 every cycle with LEN=3 -> 12 words accepted over 24 cycles; LANE_EN=0 on stall cycles; IDX sequence unchanged.
REQ-039 RST asserted at STREAM c=2 -> next cycle all outputs 0, state IDLE, no DONE; a new START then runs a full job normally.
REQ-040 SKEW_EN undefined, LEN=5 -> LANE_EN=1111 for 5 cycles, DONE 1 cycle later.
